// File: rtl/if_fetch_queue_if.sv
// Handshake bundle for if_fetch_queue: redirect input, instruction-memory
// request/grant/response channel and the valid/ready channel toward decode.
interface if_fetch_queue_if #(
   parameter int XLEN = 32
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;

   // The fetch queue itself.
   modport slave (
      input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_instr, out_pc
   );

   // The environment: branch unit, instruction memory and decode stage.
   modport master (
      output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Prefetching instruction fetch stage: credit-limited memory requests, in-order
// response FIFO, redirect flush with stale-response squash. IF_FQ_BYPASS_EN adds a zero-latency bypass.
module if_fetch_queue #(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 4,
   parameter int              MAX_OUTST = 2,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   if_fetch_queue_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OUT_W = $clog2(MAX_OUTST + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = CNT_W + 1;

   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
   localparam logic [SUM_W-1:0] DEPTH_S     = SUM_W'(DEPTH);
   localparam logic [OUT_W-1:0] MAX_OUTST_C = OUT_W'(MAX_OUTST);
   localparam logic [XLEN-1:0]  PC_STEP     = XLEN'(4);
   localparam logic [XLEN-1:0]  ALIGN_MASK  = ~XLEN'(3);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
   logic [OUT_W-1:0] outst_q, outst_d;
   logic [OUT_W-1:0] discard_q, discard_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [XLEN-1:0]  hold_instr_q, hold_instr_d;
   logic [XLEN-1:0]  hold_pc_q, hold_pc_d;

   logic [XLEN-1:0]  instr_mem_q [DEPTH];
   logic [XLEN-1:0]  pc_mem_q    [DEPTH];

   logic             redirect;
   logic             rvalid;
   logic             empty;
   logic             full;
   logic             credit_ok;
   logic             req;
   logic             gnt_fire;
   logic             drop_rsp;
   logic             accept_rsp;
   logic             bypass;
   logic             push;
   logic             pop;
   logic [SUM_W-1:0] in_flight;
   logic [XLEN-1:0]  head_instr;
   logic [XLEN-1:0]  head_pc;
   logic [XLEN-1:0]  target_pc;

   assign redirect  = bus.redirect_valid;
   assign rvalid    = bus.imem_rvalid;
   assign empty     = (count_q == '0);
   assign full      = (count_q == DEPTH_C);
   assign target_pc = bus.redirect_pc & ALIGN_MASK;

   // Slots already filled plus slots promised to outstanding requests must fit.
   assign in_flight = SUM_W'(count_q) + SUM_W'(outst_q);
   assign credit_ok = (outst_q < MAX_OUTST_C) && (in_flight < DEPTH_S);
   assign req       = reset_n && !redirect && credit_ok;
   assign gnt_fire  = req && bus.imem_gnt;

   // A response in the redirect cycle is stale by definition.
   assign drop_rsp   = rvalid && (redirect || (discard_q != '0));
   assign accept_rsp = rvalid && !drop_rsp;

`ifdef IF_FQ_BYPASS_EN
   assign bypass = empty && (discard_q == '0) && !redirect && rvalid && bus.out_ready;
`else
   assign bypass = 1'b0;
`endif

   assign push = accept_rsp && !bypass;
   assign pop  = !empty && bus.out_ready && !redirect;

   assign head_instr = instr_mem_q[rd_ptr_q];
   assign head_pc    = pc_mem_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      resp_pc_d    = resp_pc_q;
      outst_d      = outst_q;
      discard_d    = discard_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;

      if (gnt_fire) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end

      case ({gnt_fire, rvalid})
         2'b10:   outst_d = outst_q + OUT_W'(1);
         2'b01:   outst_d = outst_q - OUT_W'(1);
         default: outst_d = outst_q;
      endcase

      if (rvalid && (discard_q != '0)) begin
         discard_d = discard_q - OUT_W'(1);
      end

      if (accept_rsp) begin
         resp_pc_d = resp_pc_q + PC_STEP;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         rd_ptr_d     = rd_ptr_q + PTR_W'(1);
         hold_instr_d = head_instr;
         hold_pc_d    = head_pc;
      end else if (bypass) begin
         hold_instr_d = bus.imem_rdata;
         hold_pc_d    = resp_pc_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Redirect overrides everything: every request still in flight becomes stale.
      if (redirect) begin
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         discard_d  = outst_q - OUT_W'(rvalid);
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q   <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         outst_q      <= '0;
         discard_q    <= '0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         resp_pc_q    <= resp_pc_d;
         outst_q      <= outst_d;
         discard_q    <= discard_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   // Storage needs no reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      end
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = fetch_pc_q;
   assign bus.out_valid = !empty || bypass;

   always_comb begin
      bus.out_instr = hold_instr_q;
      bus.out_pc    = hold_pc_q;
      if (bypass) begin
         bus.out_instr = bus.imem_rdata;
         bus.out_pc    = resp_pc_q;
      end else if (!empty) begin
         bus.out_instr = head_instr;
         bus.out_pc    = head_pc;
      end
   end

`ifndef SYNTHESIS
   a_rvalid_without_request: assert property (@(posedge clk) disable iff (!reset_n)
      !(rvalid && (outst_q == '0)));
   a_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && full && !pop));
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order memory model with variable latency, PC-stream
// reference model checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_if_fetch_queue;
   localparam int          XLEN      = 32;
   localparam int          DEPTH     = 4;
   localparam int          MAX_OUTST = 2;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
`ifdef IF_FQ_BYPASS_EN
   localparam int          FIRST_LAT = 1;
`else
   localparam int          FIRST_LAT = 2;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   if_fetch_queue_if #(.XLEN(XLEN)) bus ();

   if_fetch_queue #(
      .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   req_t pending[$];

   int ready_mode = 1;   // 0 low, 1 high, 2 random
   int gnt_mode = 1;     // 1 always, 2 random
   int lat_min = 1;
   int lat_max = 1;
   int redir_mode = 0;   // 0 none, 1 random, 2 when two outstanding, 3 with rvalid+pop, 4 immediately
   logic [31:0] redir_target = '0;
   bit redir_fired = 0;
   int gnt_cnt = 0;

   logic [31:0] fetch_model = RESET_PC;
   logic [31:0] pc_model = RESET_PC;
   bit prev_redir = 0;
   int pop_cnt = 0;
   logic [31:0] post_pc [4];
   int post_idx = 0;
   int first_gnt_cyc = -1;
   int first_valid_cyc = -1;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle of environment: memory response, grant, ready, redirect.
   task automatic step();
      bit rv;
      bit rd;
      bit rdy;
      bit vld_before;
      @(negedge clk);
      vld_before = bus.out_valid;
      rv = reset_n && (pending.size() > 0) && (pending[0].due <= cyc);
      bus.imem_rvalid = rv;
      if (rv) begin
         bus.imem_rdata = instr_of(pending[0].addr);
         void'(pending.pop_front());
      end else begin
         bus.imem_rdata = $urandom();
      end
      case (ready_mode)
         0:       rdy = 1'b0;
         1:       rdy = 1'b1;
         default: rdy = ($urandom_range(0, 9) < 7);
      endcase
      rd = 1'b0;
      case (redir_mode)
         1: begin
            if ($urandom_range(0, 49) == 0) begin
               rd = 1'b1;
               redir_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | $urandom_range(0, 31))
                                                          : $urandom();
            end
         end
         2: rd = (pending.size() == 2) && !rv;
         3: begin
            rd = rv && (pending.size() >= 1) && vld_before;
            if (rd) rdy = 1'b1;
         end
         4: rd = 1'b1;
         default: rd = 1'b0;
      endcase
      if (rd && (redir_mode != 1)) begin
         redir_mode = 0;
         redir_fired = 1;
      end
      bus.out_ready = rdy;
      bus.redirect_valid = rd;
      bus.redirect_pc = rd ? redir_target : $urandom();
      bus.imem_gnt = (gnt_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (reset_n && bus.imem_req && bus.imem_gnt) begin
         pending.push_back('{addr: bus.imem_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
         gnt_cnt++;
      end
      cyc++;
   endtask

   // Compare process: reference PC model checked against the DUT every cycle.
   always @(negedge clk) begin
      #2;
      if (!reset_n) begin
         check("reset_imem_req", {31'b0, bus.imem_req}, 32'd0);
         check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
         check("reset_out_pc", bus.out_pc, 32'd0);
         check("reset_out_instr", bus.out_instr, 32'd0);
         fetch_model = RESET_PC;
         pc_model = RESET_PC;
         prev_redir = 0;
      end else begin
         if (bus.imem_req) check("imem_addr", bus.imem_addr, fetch_model);
         if (bus.redirect_valid) check("req_in_redirect", {31'b0, bus.imem_req}, 32'd0);
         if (prev_redir) check("valid_after_redirect", {31'b0, bus.out_valid}, 32'd0);
         if (bus.out_valid && !bus.redirect_valid) begin
            check("out_pc", bus.out_pc, pc_model);
            check("out_instr", bus.out_instr, instr_of(bus.out_pc));
         end
         check("outstanding_bound", {31'b0, pending.size() <= MAX_OUTST}, 32'd1);
         if (first_gnt_cyc < 0 && bus.imem_req && bus.imem_gnt) first_gnt_cyc = cyc;
         if (first_valid_cyc < 0 && bus.out_valid) first_valid_cyc = cyc;
         if (bus.redirect_valid) begin
            fetch_model = bus.redirect_pc & ~32'h3;
            pc_model = bus.redirect_pc & ~32'h3;
            post_idx = 0;
         end else begin
            if (bus.imem_req && bus.imem_gnt) fetch_model = fetch_model + 32'd4;
            if (bus.out_valid && bus.out_ready) begin
               if (post_idx < 4) begin
                  post_pc[post_idx] = bus.out_pc;
                  post_idx++;
               end
               pop_cnt++;
               pc_model = pc_model + 32'd4;
            end
         end
         prev_redir = bus.redirect_valid;
      end
   end

   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) post_pc[i] = '1;

      // Reset, released mid-cycle; 1-cycle memory, ID always ready.
      repeat (3) step();
      @(posedge clk);
      #2 reset_n = 1'b1;
      post_idx = 0;
      repeat (12) step();
      check("first_latency", first_valid_cyc - first_gnt_cyc, FIRST_LAT);
      check("s1_pc0", post_pc[0], 32'h0);
      check("s1_pc1", post_pc[1], 32'h4);
      check("s1_pc2", post_pc[2], 32'h8);
      check("s1_pc3", post_pc[3], 32'hC);

      // Stall decode right after a redirect: FIFO fills, requests stop.
      ready_mode = 0;
      redir_target = 32'h0000_0200;
      redir_mode = 4;
      step();
      gnt_cnt = 0;
      repeat (20) step();
      check("full_grants", gnt_cnt, DEPTH);
      check("full_req_low", {31'b0, bus.imem_req}, 32'd0);
      check("full_valid", {31'b0, bus.out_valid}, 32'd1);
      ready_mode = 1;
      repeat (10) step();
      check("drain_pc0", post_pc[0], 32'h200);
      check("drain_pc1", post_pc[1], 32'h204);
      check("drain_pc2", post_pc[2], 32'h208);
      check("drain_pc3", post_pc[3], 32'h20C);

      // Redirect with two requests in flight at 3-cycle latency.
      lat_min = 3;
      lat_max = 3;
      redir_target = 32'h0000_0101;
      redir_fired = 0;
      redir_mode = 2;
      for (int i = 0; i < 30 && !redir_fired; i++) step();
      check("redir2_fired", {31'b0, redir_fired}, 32'd1);
      repeat (15) step();
      check("redir2_pc0", post_pc[0], 32'h100);
      check("redir2_pc1", post_pc[1], 32'h104);

      // Redirect coinciding with a response and a pop.
      ready_mode = 0;
      redir_target = 32'h0000_0280;
      redir_mode = 4;
      repeat (7) step();
      redir_target = 32'h0000_0302;
      redir_fired = 0;
      redir_mode = 3;
      for (int i = 0; i < 30 && !redir_fired; i++) step();
      check("redir3_fired", {31'b0, redir_fired}, 32'd1);
      ready_mode = 1;
      repeat (15) step();
      check("redir3_pc0", post_pc[0], 32'h300);
      check("redir3_pc1", post_pc[1], 32'h304);

      // Random grant/latency/ready/redirect traffic.
      ready_mode = 2;
      gnt_mode = 2;
      lat_min = 1;
      lat_max = 5;
      redir_mode = 1;
      pop_cnt = 0;
      repeat (10000) step();
      check("random_progress", {31'b0, pop_cnt > 1000}, 32'd1);

      // Reset in the middle of traffic; memory side is reset too.
      ready_mode = 1;
      gnt_mode = 1;
      lat_min = 1;
      lat_max = 1;
      redir_mode = 0;
      repeat (5) step();
      #2 reset_n = 1'b0;
      pending.delete();
      repeat (2) step();
      @(posedge clk);
      #2 reset_n = 1'b1;
      post_idx = 0;
      repeat (8) step();
      check("rst2_pc0", post_pc[0], 32'h0);
      check("rst2_pc1", post_pc[1], 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage.
- Decouples PC generation from decode with a prefetch FIFO, an external instruction-memory request/grant/response interface with variable latency, and a valid/ready output toward ID.
- Branch/jump redirects flush queued instructions and squash in-flight responses.
- Sits between the instruction memory (or I-cache) and the IF/ID pipeline register.

Parameters:
- XLEN, 32, address/instruction width
- DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
- MAX_OUTST, 2, max outstanding memory requests (1..DEPTH)
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  XLEN  new fetch address (bits [1:0] ignored, treated as 0)
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request word address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  XLEN  response instruction
- out_valid  out  1  instruction available to ID
- out_ready  in  1  ID accepts (low = stall)
- out_instr  out  XLEN  instruction at FIFO head
- out_pc  out  XLEN  PC of out_instr

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = resp_pc = RESET_PC.
  - FIFO empty, outstanding = 0, discard = 0.
  - imem_req = 0, out_valid = 0, out_instr = 0, out_pc = 0.
- Credit rule: imem_req = !redirect_valid && (outstanding < MAX_OUTST) && (count + outstanding < DEPTH).
  - A granted response always has a FIFO slot.
  - imem_addr = fetch_pc.
- On imem_req && imem_gnt: fetch_pc += 4 (wraps at 2^XLEN); outstanding += 1.
- On imem_rvalid: outstanding -= 1 (a simultaneous grant nets to 0).
  - If discard > 0: drop the response and decrement discard.
  - Else: push {imem_rdata, resp_pc}, then resp_pc += 4.
- Output:
  - out_valid = !empty.
  - out_instr/out_pc come from the FIFO head; pop on out_valid && out_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full and empty.
  - Minimum latency is rvalid to out_valid in the next cycle.
  - When not valid, out_instr/out_pc hold the last value and are don't-care.
- Redirect (highest priority):
  - In the redirect_valid cycle, imem_req = 0 and any out_ready pop is ignored.
  - Next cycle: FIFO empty; fetch_pc = resp_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - discard = outstanding - imem_rvalid. All in-flight requests are stale, and a response arriving in the redirect cycle is itself dropped.
  - First new request is issued the cycle after redirect.
  - Back-to-back redirects: each recomputes discard from current outstanding; the last target wins.
- Reset mid-operation: all state clears immediately. The memory side must also be reset, because stale responses after reset are not tracked.
- Counters: outstanding and discard are sized clog2(MAX_OUTST+1); count is sized clog2(DEPTH+1).
- Assertions (sim only):
  - rvalid with outstanding == 0 is an error.
  - Push when full is an error.

Optional Feature:
- Macro IF_FQ_BYPASS_EN.
- Defined: when the FIFO is empty, discard == 0, no redirect, imem_rvalid && out_ready:
  - imem_rdata/resp_pc drive out_instr/out_pc combinationally.
  - out_valid = 1 in the same cycle.
  - No FIFO push; resp_pc still increments.
  - Zero-cycle latency.
- Not defined: out_valid is driven only from FIFO state, giving a registered output with minimum latency of 1 cycle.

Test Plan:
- Reset with reset_n=0 mid-cycle, then release; memory returns a fixed 1-cycle response, out_ready=1 -> imem_addr sequence 0x0,0x4,0x8...; out_pc 0x0,0x4,0x8 in order with matching out_instr; out_valid first high 2 cycles after first grant.
- out_ready=0 held 20 cycles -> count reaches DEPTH=4; imem_req drops; no push when full; after release, 4 instrs drain in order with no loss or duplication.
- Redirect to 0x100 while 2 requests are outstanding (3-cycle latency) -> both stale responses dropped; next out_pc=0x100, then 0x104; no stale PC ever valid.
- Redirect in the same cycle as imem_rvalid and an out_ready pop -> arriving response dropped, pop ignored, discard = outstanding-1; next out_pc = target.
- Random gnt/rvalid latency 1-5, random out_ready, random redirects over 10k cycles vs. reference PC model -> out_pc stream equals the model, outstanding <= MAX_OUTST, no assertion fires.
- With IF_FQ_BYPASS_EN, empty FIFO, rvalid && out_ready -> out_valid high in the same cycle, out_pc = resp_pc; without the macro -> out_valid high the following cycle.
